pipe_stage_ctrl: RTL and testbench

//  Parametrised successor to the fixed 5-stage operation controller.
//  - Tracks one token per pipeline stage for N_STAGES stages.
//  - Supports multi-cycle stages through per-stage done inputs, with back-pressure between stages.
//  - Supports a front-end flush.
//  - Emits a one-cycle start pulse per stage (opr_en) that drives the fetch/decode/ex/mem/wb update inputs.

---
 rtl/pipe_stage_ctrl_pkg.sv | 34 +++
 rtl/pipe_stage_ctrl_if.sv | 56 +++++
 rtl/pipe_stage_ctrl_sat_cnt.sv | 30 +++
 rtl/pipe_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_ctrl_pkg
//   Shared definitions for the parametrised pipeline stage controller.
//   - stage_e        : symbolic names for the classic five-stage layout
//   - DEF_*          : default geometry used by the controller and its interface
//   - popcnt()       : occupancy popcount, sized for up to MAX_STAGES stages
// -----------------------------------------------------------------------------
package pipe_stage_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } stage_e;

  localparam int DEF_N_STAGES    = 5;
  localparam int DEF_FLUSH_DEPTH = 2;
  localparam int DEF_CNT_W       = 16;

  // Upper bound on N_STAGES supported by popcnt().
  localparam int MAX_STAGES      = 32;

  function automatic int unsigned popcnt(input logic [MAX_STAGES-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_ctrl_if
//   Handshake and status bundle between a pipeline issue/stage agent (master)
//   and pipe_stage_ctrl (slave).
//   master drives : valid, stage_done[N_STAGES], flush
//   slave drives  : ready, opr_en[N_STAGES], occ[N_STAGES], retire,
//                   inflight[$clog2(N_STAGES+1)], stall_cnt[CNT_W],
//                   retire_cnt[CNT_W]
// -----------------------------------------------------------------------------
interface pipe_stage_ctrl_if
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int CNT_W    = DEF_CNT_W
);

  localparam int INF_W = $clog2(N_STAGES + 1);

  logic                valid;
  logic                ready;
  logic [N_STAGES-1:0] stage_done;
  logic                flush;
  logic [N_STAGES-1:0] opr_en;
  logic [N_STAGES-1:0] occ;
  logic                retire;
  logic [INF_W-1:0]    inflight;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    retire_cnt;

  modport master (
    output valid,
    output stage_done,
    output flush,
    input  ready,
    input  opr_en,
    input  occ,
    input  retire,
    input  inflight,
    input  stall_cnt,
    input  retire_cnt
  );

  modport slave (
    input  valid,
    input  stage_done,
    input  flush,
    output ready,
    output opr_en,
    output occ,
    output retire,
    output inflight,
    output stall_cnt,
    output retire_cnt
  );

endinterface

// File: rtl/pipe_stage_ctrl_sat_cnt.sv
// -----------------------------------------------------------------------------
// pipe_sat_cnt
//   Saturating up-counter used for the optional performance counters.
//   Only compiled when PIPE_CTRL_PERF_EN is defined, so a default build
//   carries no counter logic at all.
//   clk   in  clock, rising edge
//   reset in  synchronous, active-high; clears the count
//   inc   in  add one this cycle (ignored once at all-ones)
//   cnt   out current count, holds at 2**CNT_W-1
// -----------------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
module pipe_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/pipe_stage_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stage_ctrl
//   Token tracker for an N_STAGES-deep in-order pipeline. One token per stage;
//   a stage hands its token on when its stage_done is high and the next stage
//   is empty or itself emptying in the same cycle. A one-cycle opr_en pulse
//   marks each token entering a stage. flush kills stages 0..FLUSH_DEPTH-1
//   along with anything that would have entered stage FLUSH_DEPTH from them.
//
//   Parameters: N_STAGES (>=2, <=32), FLUSH_DEPTH (1..N_STAGES-1), CNT_W.
//   Ports:
//     clk    in  clock, rising edge
//     reset  in  synchronous, active-high; drops every token
//     bus    slave modport of pipe_stage_ctrl_if
//            valid/ready issue handshake into stage 0 (ready is comb)
//            stage_done per-stage completion, only meaningful while occupied
//            flush      front-end kill
//            opr_en/occ/inflight registered; retire comb
//            stall_cnt/retire_cnt saturating performance counters
//
//   Build option: PIPE_CTRL_PERF_EN enables stall_cnt/retire_cnt; without it
//   both read as zero and no counter registers exist. Ports are identical.
// -----------------------------------------------------------------------------
module pipe_stage_ctrl
  import pipe_stage_ctrl_pkg::*;
#(
  parameter int N_STAGES    = DEF_N_STAGES,
  parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_ctrl_if.slave bus
);

  localparam int INF_W = $clog2(N_STAGES + 1);

  logic [N_STAGES-1:0] occ_q;
  logic [N_STAGES-1:0] opr_en_q;
  logic [INF_W-1:0]    inflight_q;

  logic [N_STAGES-1:0] adv;
  logic [N_STAGES-1:0] entry;
  logic [N_STAGES-1:0] occ_d;
  logic                ready;
  logic                accept;

  // Advance chain, built from the writeback end toward fetch: a stage can only
  // move if the stage ahead is empty or moving out in the same cycle. Each
  // link is its own net so the chain is a plain combinational ripple.
  for (genvar j = 0; j < N_STAGES; j++) begin : g_adv
    localparam int I = N_STAGES - 1 - j;
    logic adv_i;
    if (j == 0) begin : g_tail
      assign adv_i = occ_q[I] & bus.stage_done[I];
    end else begin : g_link
      assign adv_i = occ_q[I] & bus.stage_done[I] &
                     (~occ_q[I+1] | g_adv[j-1].adv_i);
    end
    assign adv[I] = adv_i;
  end

  assign ready  = ~occ_q[0] | adv[0];
  assign accept = bus.valid & ready & ~bus.flush;

  // Entries into flushed stages, and into the first surviving stage from a
  // flushed one, are suppressed so neither occ nor opr_en sees a dead token.
  for (genvar i = 0; i < N_STAGES; i++) begin : g_next
    if (i == 0) begin : g_issue
      assign entry[i] = accept;
    end else if (i <= FLUSH_DEPTH) begin : g_front
      assign entry[i] = adv[i-1] & ~bus.flush;
    end else begin : g_back
      assign entry[i] = adv[i-1];
    end

    if (i < FLUSH_DEPTH) begin : g_kill
      assign occ_d[i] = ~bus.flush & ((occ_q[i] & ~adv[i]) | entry[i]);
    end else begin : g_keep
      assign occ_d[i] = (occ_q[i] & ~adv[i]) | entry[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q      <= '0;
      opr_en_q   <= '0;
      inflight_q <= '0;
    end else begin
      occ_q      <= occ_d;
      opr_en_q   <= entry;
      inflight_q <= INF_W'(popcnt(MAX_STAGES'(occ_d)));
    end
  end

  assign bus.ready    = ready;
  assign bus.retire   = adv[N_STAGES-1];
  assign bus.occ      = occ_q;
  assign bus.opr_en   = opr_en_q;
  assign bus.inflight = inflight_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] retire_cnt;

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.valid & ~ready),
    .cnt   (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (adv[N_STAGES-1]),
    .cnt   (retire_cnt)
  );

  assign bus.stall_cnt  = stall_cnt;
  assign bus.retire_cnt = retire_cnt;
`else
  assign bus.stall_cnt  = '0;
  assign bus.retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_ctrl
//   Directed bench for pipe_stage_ctrl. Retire timing is checked by a monitor
//   that pops expected retire cycles pushed at issue time; occupancy, pulses
//   and counters are checked against hand-computed constants. A second
//   instance with CNT_W=4 shadows the same stimulus to exercise saturation.
// -----------------------------------------------------------------------------
module tb_pipe_stage_ctrl;
  import pipe_stage_ctrl_pkg::*;

  localparam int N = DEF_N_STAGES;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   sb_en = 1'b0;
  int   exp_q[$];
  int   sb_exp;

  pipe_stage_ctrl_if #(.N_STAGES(N), .CNT_W(16)) bus  ();
  pipe_stage_ctrl_if #(.N_STAGES(N), .CNT_W(4))  bus4 ();

  pipe_stage_ctrl #(.N_STAGES(N), .FLUSH_DEPTH(2), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipe_stage_ctrl #(.N_STAGES(N), .FLUSH_DEPTH(2), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  assign bus4.valid      = bus.valid;
  assign bus4.stage_done = bus.stage_done;
  assign bus4.flush      = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Retire scoreboard: every retire must match the next expected cycle.
  always @(negedge clk) begin
    if (sb_en && !reset && bus.retire === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_retire: retire at cycle %0d, no token expected", cyc);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("sb_retire_cycle", cyc, sb_exp);
      end
    end
  end

  initial begin
    bus.valid      = 1'b0;
    bus.stage_done = '0;
    bus.flush      = 1'b0;
    reset          = 1'b1;
    tick();
    tick();

    // Reset state
    @(negedge clk);
    chk("rst_occ",        bus.occ,        0);
    chk("rst_opr_en",     bus.opr_en,     0);
    chk("rst_inflight",   bus.inflight,   0);
    chk("rst_ready",      bus.ready,      1);
    chk("rst_retire",     bus.retire,     0);
    chk("rst_stall_cnt",  bus.stall_cnt,  0);
    chk("rst_retire_cnt", bus.retire_cnt, 0);
    tick();
    reset          = 1'b0;
    bus.stage_done = '1;

    // T1: single token walks the pipe
    sb_en     = 1'b1;
    bus.valid = 1'b1;
    exp_q.push_back(cyc + N);
    @(negedge clk);
    chk("t1_ready", bus.ready, 1);
    tick();
    bus.valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("t1_opr_en",   bus.opr_en,   32'd1 << i);
      chk("t1_occ",      bus.occ,      32'd1 << i);
      chk("t1_inflight", bus.inflight, 1);
      tick();
    end
    @(negedge clk);
    chk("t1_occ_empty",      bus.occ,      0);
    chk("t1_inflight_empty", bus.inflight, 0);
    chk("t1_retire_empty",   bus.retire,   0);
    tick();

    // T2: eight back-to-back tokens
    for (int j = 0; j < 8; j++) begin
      bus.valid = 1'b1;
      exp_q.push_back(cyc + N);
      @(negedge clk);
      chk("t2_ready", bus.ready, 1);
      if (j == 5) chk("t2_inflight_full", bus.inflight, 5);
      tick();
    end
    bus.valid = 1'b0;
    repeat (N + 2) tick();
    @(negedge clk);
    chk("t2_sb_drained", exp_q.size(), 0);
    chk("t2_occ",        bus.occ,       0);
    chk("t2_stall_cnt",  bus.stall_cnt, 0);
    tick();
    sb_en = 1'b0;

    // T3: full pipe, stage 2 held busy for four cycles
    repeat (N) begin
      bus.valid = 1'b1;
      tick();
    end
    bus.stage_done = 5'b11011;
    @(negedge clk);
    chk("t3_h0_occ",    bus.occ,    5'b11111);
    chk("t3_h0_ready",  bus.ready,  0);
    chk("t3_h0_retire", bus.retire, 1);
    tick();
    @(negedge clk);
    chk("t3_h1_occ",    bus.occ,    5'b10111);
    chk("t3_h1_opr_en", bus.opr_en, 5'b10000);
    chk("t3_h1_ready",  bus.ready,  0);
    tick();
    @(negedge clk);
    chk("t3_h2_occ",    bus.occ,    5'b00111);
    chk("t3_h2_opr_en", bus.opr_en, 0);
    chk("t3_h2_retire", bus.retire, 0);
    chk("t3_h2_ready",  bus.ready,  0);
    tick();
    @(negedge clk);
    chk("t3_h3_occ",    bus.occ,    5'b00111);
    chk("t3_h3_ready",  bus.ready,  0);
    tick();
    bus.valid      = 1'b0;
    bus.stage_done = '1;
    @(negedge clk);
    chk("t3_frozen_occ", bus.occ,       5'b00111);
    chk("t3_stall_cnt",  bus.stall_cnt, PERF ? 4 : 0);
    tick();
    repeat (N) tick();
    @(negedge clk);
    chk("t3_drained", bus.occ, 0);
    tick();

    // T4a: valid together with flush on an empty pipe issues nothing
    bus.valid = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("t4_vf_ready", bus.ready, 1);
    tick();
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("t4_vf_occ",    bus.occ,    0);
    chk("t4_vf_opr_en", bus.opr_en, 0);
    tick();

    // T4b: flush a full pipe. Stage 2 empties: its own token moves to 3 and
    // its refill from stage 1 is killed, so only stages 3 and 4 survive.
    repeat (N) begin
      bus.valid = 1'b1;
      tick();
    end
    bus.flush = 1'b1;
    @(negedge clk);
    chk("t4_pre_occ",    bus.occ,    5'b11111);
    chk("t4_pre_retire", bus.retire, 1);
    tick();
    bus.valid = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("t4_post_occ",    bus.occ,    5'b11000);
    chk("t4_post_opr_en", bus.opr_en, 5'b11000);
    chk("t4_post_retire", bus.retire, 1);
    tick();
    @(negedge clk);
    chk("t4_tail_occ",    bus.occ,    5'b10000);
    chk("t4_tail_opr_en", bus.opr_en, 5'b10000);
    tick();
    @(negedge clk);
    chk("t4_empty_occ", bus.occ,       0);
    chk("t4_stall_cnt", bus.stall_cnt, PERF ? 4 : 0);
    tick();

    // T5: reset mid-run with occ=10110
    bus.valid = 1'b1; tick();
    bus.valid = 1'b0; tick();
    bus.valid = 1'b1; tick();
    bus.valid = 1'b1; tick();
    bus.valid = 1'b0; tick();
    reset     = 1'b1;
    bus.valid = 1'b1;
    @(negedge clk);
    chk("t5_pre_occ",      bus.occ,      5'b10110);
    chk("t5_pre_inflight", bus.inflight, 3);
    tick();
    @(negedge clk);
    chk("t5_occ",         bus.occ,         0);
    chk("t5_opr_en",      bus.opr_en,      0);
    chk("t5_inflight",    bus.inflight,    0);
    chk("t5_ready",       bus.ready,       1);
    chk("t5_stall_cnt",   bus.stall_cnt,   0);
    chk("t5_retire_cnt",  bus.retire_cnt,  0);
    chk("t5_retire_cnt4", bus4.retire_cnt, 0);
    tick();
    reset     = 1'b0;
    bus.valid = 1'b0;

    // T6: twenty retires; the 4-bit counter must hold at 15
    sb_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      bus.valid = 1'b1;
      exp_q.push_back(cyc + N);
      tick();
    end
    bus.valid = 1'b0;
    repeat (N + 2) tick();
    @(negedge clk);
    chk("t6_sb_drained",  exp_q.size(),    0);
    chk("t6_retire_cnt",  bus.retire_cnt,  PERF ? 20 : 0);
    chk("t6_retire_cnt4", bus4.retire_cnt, PERF ? 15 : 0);
    chk("t6_stall_cnt",   bus.stall_cnt,   0);
    chk("t6_occ4",        bus4.occ,        0);
    tick();
    sb_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
